// File: rtl/fifo_stim_driver.sv
// Stimulus generator for a synchronous FIFO: runs fill/drain, write-only, read-only or random runs and gathers statistics.
// Optional DRIVER_DATA_CHECK_EN adds a shadow queue that checks read data and reports err_count.
module fifo_stim_driver #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [15:0]           num_ops,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_in,
   input  logic [FIFO_WIDTH-1:0] data_out,
   input  logic                  wr_ack,
   input  logic                  overflow,
   input  logic                  underflow,
   input  logic                  full,
   input  logic                  empty,
   input  logic                  almostfull,
   input  logic                  almostempty,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count,
   output logic [15:0]           ovf_count,
   output logic [15:0]           udf_count
`ifdef DRIVER_DATA_CHECK_EN
   ,
   output logic [15:0]           err_count
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_WONLY = 3'd3;
   localparam logic [2:0] S_RONLY = 3'd4;
   localparam logic [2:0] S_MIX   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [2:0]  state;
   logic [2:0]  nxt_state;
   logic        nxt_wr;
   logic        nxt_rd;
   logic [15:0] lfsr;
   logic [15:0] op_cnt;
   logic [15:0] ops_lim;
   logic [1:0]  tail;
   logic        start_go;
   logic        count_en;
   logic        ops_left;
   logic        unused_inputs;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   assign start_go      = (state == S_IDLE) && start;
   // Statistics keep sampling for two cycles after DONE to catch late FIFO status.
   assign count_en      = (state != S_IDLE) || (tail != 2'd0);
   assign ops_left      = (op_cnt < ops_lim);
   assign unused_inputs = ^{almostfull, almostempty, data_out};

   // Next-state and next-enable decision from flags sampled at this edge
   always_comb begin
      nxt_state = state;
      nxt_wr    = 1'b0;
      nxt_rd    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (mode)
                  2'b00:   nxt_state = S_FILL;
                  2'b01:   nxt_state = S_WONLY;
                  2'b10:   nxt_state = S_RONLY;
                  2'b11:   nxt_state = S_MIX;
                  default: nxt_state = S_IDLE;
               endcase
            end else begin
               nxt_state = S_IDLE;
            end
         end
         S_FILL: begin
            if (!ops_left) begin
               nxt_state = S_DONE;
            end else if (full) begin
               nxt_state = S_DRAIN;
               nxt_rd    = 1'b1;
            end else begin
               nxt_wr    = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!ops_left) begin
               nxt_state = S_DONE;
            end else if (empty) begin
               nxt_state = S_FILL;
               nxt_wr    = 1'b1;
            end else begin
               nxt_rd    = 1'b1;
            end
         end
         S_WONLY: begin
            if (!ops_left) begin
               nxt_state = S_DONE;
            end else begin
               nxt_wr    = 1'b1;
            end
         end
         S_RONLY: begin
            if (!ops_left) begin
               nxt_state = S_DONE;
            end else begin
               nxt_rd    = 1'b1;
            end
         end
         S_MIX: begin
            if (!ops_left) begin
               nxt_state = S_DONE;
            end else begin
               nxt_wr    = lfsr[0];
               nxt_rd    = lfsr[1];
            end
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
   end

   // FSM, registered FIFO controls, LFSR and op counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         data_in <= {FIFO_WIDTH{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         lfsr    <= LFSR_SEED;
         op_cnt  <= 16'd0;
         ops_lim <= 16'd0;
         tail    <= 2'd0;
      end else begin
         state <= nxt_state;
         wr_en <= nxt_wr;
         rd_en <= nxt_rd;
         busy  <= (nxt_state != S_IDLE);
         done  <= (nxt_state == S_DONE);
         if (nxt_wr) begin
            data_in <= lfsr[FIFO_WIDTH-1:0];
         end else begin
            data_in <= data_in;
         end
         if (start_go) begin
            lfsr    <= LFSR_SEED;
            op_cnt  <= 16'd0;
            ops_lim <= num_ops;
            tail    <= 2'd0;
         end else begin
            if (state != S_IDLE) begin
               lfsr <= lfsr_next(lfsr);
            end else begin
               lfsr <= lfsr;
            end
            if (nxt_wr || nxt_rd) begin
               op_cnt <= op_cnt + 16'd1;
            end else begin
               op_cnt <= op_cnt;
            end
            if (state == S_DONE) begin
               tail <= 2'd2;
            end else if (tail != 2'd0) begin
               tail <= tail - 2'd1;
            end else begin
               tail <= tail;
            end
         end
      end
   end

   // Saturating run statistics, cleared at start and held between runs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count  <= 16'd0;
         rd_count  <= 16'd0;
         ovf_count <= 16'd0;
         udf_count <= 16'd0;
      end else if (start_go) begin
         wr_count  <= 16'd0;
         rd_count  <= 16'd0;
         ovf_count <= 16'd0;
         udf_count <= 16'd0;
      end else if (count_en) begin
         wr_count  <= sat_inc(wr_count, wr_ack);
         rd_count  <= sat_inc(rd_count, rd_en && !empty);
         ovf_count <= sat_inc(ovf_count, overflow);
         udf_count <= sat_inc(udf_count, underflow);
      end else begin
         wr_count  <= wr_count;
         rd_count  <= rd_count;
         ovf_count <= ovf_count;
         udf_count <= udf_count;
      end
   end

`ifdef DRIVER_DATA_CHECK_EN
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [FIFO_WIDTH-1:0] shadow [FIFO_DEPTH];
   logic [FIFO_WIDTH-1:0] data_in_d;
   logic [FIFO_WIDTH-1:0] head;
   logic [FIFO_WIDTH-1:0] chk_exp;
   logic [PW-1:0]         sh_wp;
   logic [PW-1:0]         sh_rp;
   logic [CW-1:0]         sh_cnt;
   logic                  push;
   logic                  pop;
   logic                  bypass;
   logic                  store;
   logic                  take;
   logic                  chk_pend;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // wr_ack trails the write by a cycle, so the accepted word is the delayed data_in.
   assign push   = count_en && wr_ack;
   assign pop    = count_en && rd_en && !empty;
   assign bypass = push && pop && (sh_cnt == {CW{1'b0}});
   assign store  = push && !bypass && ((sh_cnt != CW'(FIFO_DEPTH)) || pop);
   assign take   = pop && (sh_cnt != {CW{1'b0}});
   assign head   = (sh_cnt == {CW{1'b0}}) ? data_in_d : shadow[sh_rp];

   // Shadow storage of accepted write data
   always_ff @(posedge clk) begin
      if (store) begin
         shadow[sh_wp] <= data_in_d;
      end else begin
         shadow[sh_wp] <= shadow[sh_wp];
      end
   end

   // Shadow pointers and one-cycle-late read data comparison
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_in_d <= {FIFO_WIDTH{1'b0}};
         chk_exp   <= {FIFO_WIDTH{1'b0}};
         sh_wp     <= {PW{1'b0}};
         sh_rp     <= {PW{1'b0}};
         sh_cnt    <= {CW{1'b0}};
         chk_pend  <= 1'b0;
         err_count <= 16'd0;
      end else begin
         data_in_d <= data_in;
         if (start_go) begin
            chk_exp   <= {FIFO_WIDTH{1'b0}};
            sh_wp     <= {PW{1'b0}};
            sh_rp     <= {PW{1'b0}};
            sh_cnt    <= {CW{1'b0}};
            chk_pend  <= 1'b0;
            err_count <= 16'd0;
         end else begin
            sh_wp     <= store ? ptr_inc(sh_wp) : sh_wp;
            sh_rp     <= take ? ptr_inc(sh_rp) : sh_rp;
            sh_cnt    <= sh_cnt + CW'(store) - CW'(take);
            chk_pend  <= pop;
            chk_exp   <= head;
            err_count <= sat_inc(err_count, chk_pend && (data_out != chk_exp));
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: behavioural sync FIFO, scoreboard of expected write data, directed runs in every mode.
module tb_fifo_stim_driver;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [15:0] num_ops = 16'd0;
   logic        wr_en, rd_en, busy, done;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
   logic [15:0] wr_count, rd_count, ovf_count, udf_count;
`ifdef DRIVER_DATA_CHECK_EN
   logic [15:0] err_count;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [15:0] sb_q[$];
   int          mix_edges, mix_wr, mix_rd;

   always #5 clk = ~clk;

   fifo_stim_driver #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .num_ops(num_ops),
      .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
      .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .full(full),
      .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
      .busy(busy), .done(done), .wr_count(wr_count), .rd_count(rd_count),
      .ovf_count(ovf_count), .udf_count(udf_count)
`ifdef DRIVER_DATA_CHECK_EN
      , .err_count(err_count)
`endif
   );

   // Behavioural 8-deep synchronous FIFO with registered ack/overflow/underflow
   logic [15:0] fmem [8];
   logic [2:0]  fwp, frp;
   logic [3:0]  f_cnt;
   logic        wr_ok, rd_ok;
   assign full        = (f_cnt == 4'd8);
   assign empty       = (f_cnt == 4'd0);
   assign almostfull  = (f_cnt == 4'd7);
   assign almostempty = (f_cnt == 4'd1);
   assign wr_ok       = wr_en && !full;
   assign rd_ok       = rd_en && !empty;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fwp <= 3'd0; frp <= 3'd0; f_cnt <= 4'd0; data_out <= 16'd0;
         wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_ok;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
         if (wr_ok) begin
            fmem[fwp] <= data_in;
            fwp <= fwp + 3'd1;
         end
         if (rd_ok) begin
            data_out <= fmem[frp];
            frp <= frp + 3'd1;
         end
         f_cnt <= f_cnt + {3'd0, wr_ok} - {3'd0, rd_ok};
      end
   end

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] v;
      v = SEED;
      for (int i = 0; i < n; i++) v = lstep(v);
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_range(input int first, input int last);
      for (int i = first; i <= last; i++) sb_q.push_back(lfsr_at(i));
   endtask

   task automatic build_mix(input int n);
      logic [15:0] v;
      int ops, i, last;
      v = SEED; ops = 0; i = 0; last = -1; mix_wr = 0; mix_rd = 0;
      while (ops < n) begin
         if (v[0]) begin sb_q.push_back(v); mix_wr++; end
         if (v[1]) mix_rd++;
         if (v[1:0] != 2'b00) begin ops++; last = i; end
         v = lstep(v);
         i++;
      end
      mix_edges = last + 2;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_rd_en", {31'd0, rd_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_data_in", {16'd0, data_in}, 32'd0);
      check("rst_counts", {wr_count | rd_count, ovf_count | udf_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic start_run(input logic [1:0] m, input logic [15:0] n);
      @(negedge clk);
      mode = m; num_ops = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int restart_at, input int e_edges, input int e_wr, input int e_rd);
      int found, edges, nwr, nrd;
      found = 0; edges = 0; nwr = 0; nrd = 0;
      for (int k = 0; k < 2000 && found == 0; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (wr_en) begin
            nwr++;
            if (sb_q.size() == 0) check("sb_extra_write", 32'd1, 32'd0);
            else check("data_in", {16'd0, data_in}, {16'd0, sb_q.pop_front()});
         end
         if (rd_en) nrd++;
         if (done) begin found = 1; edges = k + 1; end
      end
      start = 1'b0;
      check("done_seen", found, 32'd1);
      check("done_latency", edges, e_edges);
      check("wr_cycles", nwr, e_wr);
      check("rd_cycles", nrd, e_rd);
      check("sb_drained", sb_q.size(), 32'd0);
      @(negedge clk);
      check("done_one_cycle", {30'd0, done, busy}, 32'd0);
   endtask

   task automatic check_counts(input int e_w, input int e_r, input int e_o, input int e_u);
      repeat (4) @(negedge clk);
      check("wr_count", wr_count, e_w);
      check("rd_count", rd_count, e_r);
      check("ovf_count", ovf_count, e_o);
      check("udf_count", udf_count, e_u);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("init_outputs", {wr_en, rd_en, busy, done}, 32'd0);
      check("init_counts", {wr_count | rd_count, ovf_count | udf_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // fill-then-drain: 9 writes, 9 reads, 2 writes
      push_range(0, 8);
      push_range(18, 19);
      start_run(2'b00, 16'd20);
      wait_done(-1, 21, 11, 9);
      check_counts(10, 8, 1, 1);

      // write-only on an empty FIFO
      pulse_reset();
      push_range(0, 11);
      start_run(2'b01, 16'd12);
      wait_done(-1, 13, 12, 0);
      check_counts(8, 0, 4, 0);

      // read-only on an empty FIFO
      pulse_reset();
      start_run(2'b10, 16'd5);
      wait_done(-1, 6, 0, 5);
      check_counts(0, 0, 0, 5);

      // reset during FILL after op 4 aborts the run without done
      pulse_reset();
      start_run(2'b00, 16'd20);
      repeat (4) @(negedge clk);
      check("fill_before_rst", {30'd0, wr_en, busy}, 32'd3);
      rst = 1'b1;
      #1;
      check("abort_outputs", {wr_en, rd_en, busy, done}, 32'd0);
      check("abort_data_in", {16'd0, data_in}, 32'd0);
      check("abort_counts", {wr_count | rd_count, ovf_count | udf_count}, 32'd0);
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      push_range(0, 2);
      start_run(2'b00, 16'd3);
      wait_done(-1, 4, 3, 0);
      check_counts(3, 0, 0, 0);

      // mixed random run
      pulse_reset();
      build_mix(100);
      start_run(2'b11, 16'd100);
      wait_done(-1, mix_edges, mix_wr, mix_rd);
      check_counts(wr_count, rd_count, ovf_count, udf_count);
      check("mix_writes_total", wr_count + ovf_count, mix_wr);
      check("mix_reads_total", rd_count + udf_count, mix_rd);
      check("mix_occupancy", wr_count - rd_count, {28'd0, f_cnt});
`ifdef DRIVER_DATA_CHECK_EN
      check("mix_err_count", err_count, 32'd0);
`endif

      // start re-pulsed while busy is ignored
      pulse_reset();
      push_range(0, 11);
      start_run(2'b01, 16'd12);
      wait_done(4, 13, 12, 0);
      check_counts(8, 0, 4, 0);

      // num_ops = 0 finishes the edge after start with zero statistics
      start_run(2'b00, 16'd0);
      wait_done(-1, 1, 0, 0);
      check_counts(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_stim_driver.md
FIFO_STIM_DRIVER -- requirements
Module: fifo_stim_driver

Interface
REQ-001 Parameter FIFO_WIDTH, 16, data width driven to the FIFO, 1..16.
REQ-002 Parameter FIFO_DEPTH, 8, depth of the attached sync FIFO.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse, begins a run when idle.
REQ-006 mode  in  2  00 fill-then-drain, 01 write-only, 10 read-only, 11 mixed random.
REQ-007 num_ops  in  16  number of op cycles per run.
REQ-008 wr_en, rd_en  out  1 each  registered FIFO enables.
REQ-009 data_in  out  FIFO_WIDTH  registered write data.
REQ-010 data_out  in  FIFO_WIDTH  FIFO read data, unused except under REQ-032.
REQ-011 wr_ack, overflow, underflow, full, empty, almostfull, almostempty  in  1 each  FIFO status.
REQ-012 busy, done  out  1 each  run active; one-cycle completion pulse.
REQ-013 wr_count, rd_count, ovf_count, udf_count  out  16 each  run statistics.

Function
REQ-014 FSM states IDLE, FILL, DRAIN, WONLY, RONLY, MIX, DONE; busy=1 in all but IDLE.
REQ-015 IDLE: start=1 -> clear all counters, op_cnt=0, go FILL/WONLY/RONLY/MIX per mode; start while busy is ignored.
REQ-016 Op cycle = cycle with wr_en or rd_en high; op_cnt increments per op cycle.
REQ-017 When the next op would make op_cnt exceed num_ops, drive wr_en=rd_en=0 and go DONE; num_ops=0 -> DONE the edge after start.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; outputs low.
REQ-019 FILL: wr_en=1 each cycle; full sampled 1 at an edge -> DRAIN, wr_en=0, rd_en=1.
REQ-020 DRAIN: rd_en=1 each cycle; empty sampled 1 at an edge -> FILL, rd_en=0, wr_en=1.
REQ-021 Outputs registered: decision uses flags sampled at the same edge, so exactly one write into full (one overflow) per FILL and one read from empty (one underflow) per DRAIN; this is intended.
REQ-022 WONLY: wr_en=1 every op cycle regardless of full; RONLY: rd_en=1 every op cycle regardless of empty.
REQ-023 MIX: wr_en=lfsr[0], rd_en=lfsr[1] each cycle; simultaneous wr/rd allowed; cycles with both low do not count as ops.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset and at start; advances every busy cycle.
REQ-025 data_in=lfsr[FIFO_WIDTH-1:0] whenever wr_en=1, else holds last value.
REQ-026 wr_count +1 per cycle wr_ack=1; ovf_count +1 per cycle overflow=1; udf_count +1 per cycle underflow=1.
REQ-027 rd_count +1 per edge with rd_en=1 and empty=0.
REQ-028 All counters saturate at 16'hFFFF; hold their value after DONE until next start.
REQ-029 Status inputs sampled for 2 cycles after DONE so late wr_ack/overflow/underflow are counted; almostfull/almostempty unused.

Reset
REQ-030 rst=1 -> state IDLE, wr_en=rd_en=0, data_in=0, busy=done=0, all counters 0, op_cnt=0, lfsr=16'hACE1, immediately and asynchronously.
REQ-031 Reset mid-run aborts the run with no done pulse; release returns to IDLE awaiting start.

Configuration
REQ-032 Macro DRIVER_DATA_CHECK_EN defined: internal FIFO_DEPTH-entry shadow queue of written data (pushed on wr_ack), popped on each counted read, compared to data_out one cycle later; mismatch increments output err_count[15:0] (saturating, cleared on start/reset). Undefined: no shadow queue, no err_count port.

Verification (FIFO_DEPTH=8, FIFO_WIDTH=16)
REQ-033 mode=00, num_ops=20 -> 9 writes, 9 reads, 2 writes; wr_count=10, rd_count=8, ovf_count=1, udf_count=1, done one cycle later.
REQ-034 mode=01, num_ops=12 on empty FIFO -> wr_count=8, ovf_count=4, first data_in=lfsr[15:0] after seed 16'hACE1.
REQ-035 mode=10, num_ops=5 on empty FIFO -> rd_count=0, udf_count=5.
REQ-036 mode=11, num_ops=100 with DRIVER_DATA_CHECK_EN -> err_count=0, wr_count-rd_count equals final FIFO occupancy.
REQ-037 rst pulse during FILL at op 4 -> all outputs 0 same cycle, no done; new start with num_ops=3 -> wr_count=3, done.
REQ-038 start re-pulsed while busy -> ignored, op_cnt unaffected; num_ops=0 -> done one cycle after start, all counters 0.
